// File: rtl/if_rf_pipe_ctrl.sv
// if_rf_pipe_ctrl: IF->RF pipeline register with load-use stall and branch-flush control.
// Optional IF_RF_PERF_CNT_EN adds stall/flush performance counters.
module if_rf_pipe_ctrl #(
    parameter int          LOAD_STALL = 1,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_IF,
    input  logic [31:0] instr_IF,
    input  logic        freeze,
    input  logic        flush_RF,
    input  logic [4:0]  readA_RF,
    input  logic [4:0]  readB_RF,
    input  logic        useA_RF,
    input  logic        useB_RF,
    input  logic        mem_read_EX,
    input  logic [4:0]  regWrite_EX,
    output logic [63:0] pc_RF,
    output logic [31:0] instr_RF,
    output logic        valid_RF,
    output logic        pc_en,
    output logic        bubble_RF
`ifdef IF_RF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    // The hazard cycle in RUN is the first held cycle, so STALL covers the remaining LOAD_STALL-1.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL > 1 ? LOAD_STALL - 2 : 0);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] pc_rf_q, pc_rf_d;
    logic [31:0] instr_rf_q, instr_rf_d;
    logic        valid_rf_q, valid_rf_d;
    logic        hazard, stall;

    assign hazard = valid_rf_q & mem_read_EX & (regWrite_EX != 5'd31) &
                    ((useA_RF & (readA_RF == regWrite_EX)) | (useB_RF & (readB_RF == regWrite_EX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            if (state_q == RUN) begin
                if (hazard && LOAD_STALL > 1) begin
                    state_d = STALL;
                    cnt_d   = CNT_INIT;
                end
            end else if (cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        stall     = (state_q == RUN) ? hazard : 1'b1;
        pc_en     = ~stall & ~freeze;
        bubble_RF = stall | ~valid_rf_q;
    end

    always_comb begin
        pc_rf_d    = pc_rf_q;
        instr_rf_d = instr_rf_q;
        valid_rf_d = valid_rf_q;
        if (!freeze && !stall) begin
            pc_rf_d    = pc_IF;
            instr_rf_d = flush_RF ? NOP_INSTR : instr_IF;
            valid_rf_d = ~flush_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_rf_q    <= 64'd0;
            instr_rf_q <= NOP_INSTR;
            valid_rf_q <= 1'b0;
        end else begin
            pc_rf_q    <= pc_rf_d;
            instr_rf_q <= instr_rf_d;
            valid_rf_q <= valid_rf_d;
        end
    end

    assign pc_RF    = pc_rf_q;
    assign instr_RF = instr_rf_q;
    assign valid_RF = valid_rf_q;

`ifdef IF_RF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall & ~freeze};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_RF & ~stall & ~freeze};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_rf_pipe_ctrl.sv
// tb_if_rf_pipe_ctrl: directed bench for if_rf_pipe_ctrl with LOAD_STALL=1 (u1) and LOAD_STALL=3 (u3).
module tb_if_rf_pipe_ctrl;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset, freeze, flush_RF, useA_RF, useB_RF, mem_read_EX;
    logic [63:0] pc_IF;
    logic [31:0] instr_IF;
    logic [4:0]  readA_RF, readB_RF, regWrite_EX;
    logic [63:0] pc_rf1, pc_rf3;
    logic [31:0] instr_rf1, instr_rf3;
    logic        valid1, valid3, pc_en1, pc_en3, bubble1, bubble3;
`ifdef IF_RF_PERF_CNT_EN
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    if_rf_pipe_ctrl #(.LOAD_STALL(1)) u1 (
        .clk(clk), .reset(reset), .pc_IF(pc_IF), .instr_IF(instr_IF), .freeze(freeze),
        .flush_RF(flush_RF), .readA_RF(readA_RF), .readB_RF(readB_RF), .useA_RF(useA_RF),
        .useB_RF(useB_RF), .mem_read_EX(mem_read_EX), .regWrite_EX(regWrite_EX),
        .pc_RF(pc_rf1), .instr_RF(instr_rf1), .valid_RF(valid1), .pc_en(pc_en1), .bubble_RF(bubble1)
`ifdef IF_RF_PERF_CNT_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );

    if_rf_pipe_ctrl #(.LOAD_STALL(3)) u3 (
        .clk(clk), .reset(reset), .pc_IF(pc_IF), .instr_IF(instr_IF), .freeze(freeze),
        .flush_RF(flush_RF), .readA_RF(readA_RF), .readB_RF(readB_RF), .useA_RF(useA_RF),
        .useB_RF(useB_RF), .mem_read_EX(mem_read_EX), .regWrite_EX(regWrite_EX),
        .pc_RF(pc_rf3), .instr_RF(instr_rf3), .valid_RF(valid3), .pc_en(pc_en3), .bubble_RF(bubble3)
`ifdef IF_RF_PERF_CNT_EN
        , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        freeze = 0; flush_RF = 0; useA_RF = 0; useB_RF = 0; mem_read_EX = 0;
        readA_RF = 5'd3; readB_RF = 5'd7; regWrite_EX = 5'd3;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        pc_IF = 64'h1234; instr_IF = 32'hAAAA_0000;
        do_reset();
        checks++; if (pc_rf1 !== 64'd0) begin fails++; $display("FAIL reset_pc got %h want 0", pc_rf1); end
        checks++; if (instr_rf1 !== NOP) begin fails++; $display("FAIL reset_instr got %h want %h", instr_rf1, NOP); end
        checks++; if (valid1 !== 1'b0 || bubble1 !== 1'b1 || pc_en1 !== 1'b1) begin
            fails++; $display("FAIL reset_ctrl got valid=%b bubble=%b pc_en=%b want 0 1 1", valid1, bubble1, pc_en1);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            pc_IF = 64'(i * 4); instr_IF = 32'h1100_0000 + 32'(i);
            tick();
            checks++;
            if (pc_rf1 !== 64'(i * 4) || instr_rf1 !== 32'h1100_0000 + 32'(i) || valid1 !== 1'b1 || bubble1 !== 1'b0) begin
                fails++; $display("FAIL stream_%0d got pc=%h instr=%h valid=%b bubble=%b want pc=%h instr=%h 1 0",
                                  i, pc_rf1, instr_rf1, valid1, bubble1, 64'(i * 4), 32'h1100_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_hazard();
        pc_IF = 64'h10; instr_IF = 32'h2200_0010;
        tick();
        useA_RF = 1; readA_RF = 5'd3; mem_read_EX = 1; regWrite_EX = 5'd3;
        pc_IF = 64'h14; instr_IF = 32'h2200_0014;
        #1;
        checks++; if (pc_en1 !== 1'b0 || bubble1 !== 1'b1) begin
            fails++; $display("FAIL hazard_stall got pc_en=%b bubble=%b want 0 1", pc_en1, bubble1);
        end
        tick();
        mem_read_EX = 0;
        #1;
        checks++; if (pc_rf1 !== 64'h10 || instr_rf1 !== 32'h2200_0010) begin
            fails++; $display("FAIL hazard_hold got pc=%h instr=%h want 10 22000010", pc_rf1, instr_rf1);
        end
        checks++; if (pc_en1 !== 1'b1 || bubble1 !== 1'b0) begin
            fails++; $display("FAIL hazard_resume got pc_en=%b bubble=%b want 1 0", pc_en1, bubble1);
        end
        tick();
        checks++; if (pc_rf1 !== 64'h14) begin fails++; $display("FAIL hazard_advance got pc=%h want 14", pc_rf1); end
    endtask

    task automatic test_no_hazard();
        useA_RF = 1; readA_RF = 5'd31; mem_read_EX = 1; regWrite_EX = 5'd31;
        #1;
        checks++; if (pc_en1 !== 1'b1) begin fails++; $display("FAIL xzr_no_hazard got pc_en=%b want 1", pc_en1); end
        useA_RF = 0; readA_RF = 5'd3; regWrite_EX = 5'd3;
        #1;
        checks++; if (pc_en1 !== 1'b1) begin fails++; $display("FAIL unused_a got pc_en=%b want 1", pc_en1); end
        useB_RF = 1; readB_RF = 5'd3;
        #1;
        checks++; if (pc_en1 !== 1'b0) begin fails++; $display("FAIL hazard_b got pc_en=%b want 0", pc_en1); end
        quiet();
        #1;
    endtask

    task automatic test_flush();
        flush_RF = 1; pc_IF = 64'h40; instr_IF = 32'h3300_0040;
        tick();
        flush_RF = 0;
        checks++; if (instr_rf1 !== NOP || valid1 !== 1'b0 || bubble1 !== 1'b1 || pc_rf1 !== 64'h40) begin
            fails++; $display("FAIL flush got pc=%h instr=%h valid=%b bubble=%b want 40 %h 0 1", pc_rf1, instr_rf1, valid1, bubble1, NOP);
        end
        pc_IF = 64'h44; instr_IF = 32'h3300_0044;
        tick();
        checks++; if (valid1 !== 1'b1 || instr_rf1 !== 32'h3300_0044) begin
            fails++; $display("FAIL after_flush got valid=%b instr=%h want 1 33000044", valid1, instr_rf1);
        end
    endtask

    task automatic test_freeze_stall();
        int low1 = 0;
        int low3 = 0;
        do_reset();
        pc_IF = 64'h20; instr_IF = 32'h4400_0020;
        tick();
        useA_RF = 1; readA_RF = 5'd3; regWrite_EX = 5'd3;
        pc_IF = 64'h24; instr_IF = 32'h4400_0024;
        for (int i = 0; i < 8; i++) begin
            freeze = (i == 1 || i == 2);
            mem_read_EX = (i == 0);
            #1;
            if (!pc_en1) low1++;
            if (!pc_en3) low3++;
            if (i == 4) begin
                checks++; if (pc_rf3 !== 64'h20) begin fails++; $display("FAIL ls3_hold got pc=%h want 20", pc_rf3); end
            end
            tick();
        end
        checks++; if (low3 !== 5) begin fails++; $display("FAIL ls3_freeze_low got %0d want 5", low3); end
        checks++; if (low1 !== 3) begin fails++; $display("FAIL ls1_freeze_low got %0d want 3", low1); end
        checks++; if (pc_rf3 !== 64'h24) begin fails++; $display("FAIL ls3_resume got pc=%h want 24", pc_rf3); end
        quiet();
    endtask

    task automatic test_flush_during_stall();
        do_reset();
        pc_IF = 64'h30; instr_IF = 32'h5500_0030;
        tick();
        useA_RF = 1; mem_read_EX = 1; flush_RF = 1; pc_IF = 64'h34; instr_IF = 32'h5500_0034;
        #1;
        checks++; if (pc_en1 !== 1'b0 || bubble1 !== 1'b1) begin
            fails++; $display("FAIL flush_stall_ctrl got pc_en=%b bubble=%b want 0 1", pc_en1, bubble1);
        end
        tick();
        mem_read_EX = 0; flush_RF = 0;
        checks++; if (pc_rf1 !== 64'h30 || valid1 !== 1'b1 || instr_rf1 !== 32'h5500_0030) begin
            fails++; $display("FAIL flush_ignored got pc=%h valid=%b instr=%h want 30 1 55000030", pc_rf1, valid1, instr_rf1);
        end
`ifdef IF_RF_PERF_CNT_EN
        checks++; if (stall_cnt1 !== 32'd1 || flush_cnt1 !== 32'd0) begin
            fails++; $display("FAIL perf_one_hazard got stall=%0d flush=%0d want 1 0", stall_cnt1, flush_cnt1);
        end
        flush_RF = 1;
        tick();
        flush_RF = 0;
        checks++; if (flush_cnt1 !== 32'd1) begin fails++; $display("FAIL perf_flush got %0d want 1", flush_cnt1); end
`endif
        quiet();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        pc_IF = 64'h50; instr_IF = 32'h6600_0050;
        tick();
        useA_RF = 1; mem_read_EX = 1; pc_IF = 64'h54;
        tick();
        mem_read_EX = 0;
        #1;
        checks++; if (pc_en3 !== 1'b0) begin fails++; $display("FAIL ls3_in_stall got pc_en=%b want 0", pc_en3); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++; if (pc_en3 !== 1'b1 || valid3 !== 1'b0 || pc_rf3 !== 64'd0 || instr_rf3 !== NOP) begin
            fails++; $display("FAIL reset_mid_stall got pc_en=%b valid=%b pc=%h instr=%h want 1 0 0 %h", pc_en3, valid3, pc_rf3, instr_rf3, NOP);
        end
        pc_IF = 64'h58;
        tick();
        checks++; if (pc_rf3 !== 64'h58 || valid3 !== 1'b1) begin
            fails++; $display("FAIL run_after_reset got pc=%h valid=%b want 58 1", pc_rf3, valid3);
        end
        quiet();
    endtask

    initial begin
        quiet();
        reset = 1; pc_IF = 0; instr_IF = 0;
        test_reset();
        test_stream();
        test_hazard();
        test_no_hazard();
        test_flush();
        test_freeze_stall();
        test_flush_during_stall();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
